load_store_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 17 +
 rtl/lsu_timeout_ctr.sv | 32 +++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the core's bus-facing blocks.
package riscv_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ADDR,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  localparam int LSU_DEFAULT_TIMEOUT = 255;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Clearable saturating cycle counter with a terminal flag at LIMIT-1.
// LIMIT = 0 disables the terminal flag entirely.
module lsu_timeout_ctr
  import riscv_pkg::*;
#(
  parameter int LIMIT = LSU_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] TERM_VAL = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign term = (LIMIT > 0) && (count == TERM_VAL);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding bridge from the MEM1 LSU port to a pipelined Wishbone B4 master.
// Valid/ready: lsu_req_i is a one-cycle strobe accepted only in IDLE; lsu_req_done_o pulses once per accepted request.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_DEFAULT_TIMEOUT,
  parameter int ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic [31:0]       lsu_addr_i,
  input  logic              lsu_we_i,
  input  logic [3:0]        lsu_wsel_byte_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_req_done_o,
  output logic              lsu_err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i
);

  lsu_state_t state;
  logic       tmo_term;
  logic       resp_seen;

  assign resp_seen = wb_ack_i || wb_err_i;

  lsu_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (clk_i),
    .rst  (rst_i),
    .clr  ((state == LSU_IDLE) && lsu_req_i),
    .en   (state == LSU_WAIT),
    .term (tmo_term)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= LSU_IDLE;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_adr_o       <= '0;
      wb_sel_o       <= 4'h0;
      wb_dat_o       <= 32'h0;
      lsu_req_done_o <= 1'b0;
      lsu_err_o      <= 1'b0;
      lsu_rdata_o    <= 32'h0;
    end else begin
      lsu_req_done_o <= 1'b0;
      lsu_err_o      <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            state    <= LSU_ADDR;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= lsu_we_i;
            wb_adr_o <= ADDR_W'(word_align(lsu_addr_i));
            // Loads always fetch the full word; MEM1 does lane extraction.
            wb_sel_o <= lsu_we_i ? lsu_wsel_byte_i : 4'hF;
            wb_dat_o <= lsu_wdata_i;
          end
        end
        LSU_ADDR, LSU_WAIT: begin
          if (resp_seen) begin
            state          <= LSU_RESP;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            lsu_req_done_o <= 1'b1;
            lsu_err_o      <= wb_err_i;
            // Error beats ack in the same cycle, so the data is untrusted.
            if (wb_ack_i && !wb_err_i && !wb_we_o) begin
              lsu_rdata_o <= wb_dat_i;
            end
          end else if (state == LSU_ADDR) begin
            if (!wb_stall_i) begin
              state    <= LSU_WAIT;
              wb_stb_o <= 1'b0;
            end
          end else if (tmo_term) begin
            state          <= LSU_RESP;
            wb_cyc_o       <= 1'b0;
            lsu_req_done_o <= 1'b1;
            lsu_err_o      <= 1'b1;
          end
        end
        LSU_RESP: begin
          state <= LSU_IDLE;
        end
        default: begin
          state <= LSU_IDLE;
        end
      endcase
    end
  end

  req_only_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    lsu_req_i |-> (state == LSU_IDLE));

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with an inline Wishbone slave.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic        lsu_we_i = 1'b0;
  logic [3:0]  lsu_wsel_byte_i = 4'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic [31:0] lsu_rdata_o;
  logic        lsu_req_done_o;
  logic        lsu_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_stall_i = 1'b0;

  load_store_unit #(
    .TIMEOUT_CYCLES(4),
    .ADDR_W        (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_wsel_byte_i(lsu_wsel_byte_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_req_done_o (lsu_req_done_o),
    .lsu_err_o      (lsu_err_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i),
    .wb_stall_i     (wb_stall_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int unsigned cycle = 0;
  always @(posedge clk_i) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int unsigned done_cyc;
    int unsigned stb_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = 32'h0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout after 4 wait cycles).
  // s = stalled address cycles, d = response offset from the accepting cycle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdata, input int s, input int d,
                         input int kind, input logic [31:0] dat);
    exp_t e;
    int   resp_off;
    logic hit;
    resp_off = (kind == 3) ? s + 5 : s + d + 1;
    e.we     = we;
    e.adr    = addr & 32'hFFFF_FFFC;
    e.sel    = we ? sel : 4'hF;
    e.wdata  = wdata;
    e.err    = (kind != 0);
    if (!we && kind == 0) model_rdata = dat;
    e.rdata    = model_rdata;
    e.done_cyc = cycle + 1 + resp_off;
    e.stb_cyc  = s + 1;
    exp_q.push_back(e);
    lsu_req_i       = 1'b1;
    lsu_addr_i      = addr;
    lsu_we_i        = we;
    lsu_wsel_byte_i = sel;
    lsu_wdata_i     = wdata;
    @(negedge clk_i);
    lsu_req_i   = 1'b0;
    lsu_addr_i  = $urandom;
    lsu_wdata_i = $urandom;
    for (int k = 0; k < resp_off; k++) begin
      wb_stall_i = (k < s) ? 1'b1 : (k == s) ? 1'b0 : 1'($urandom_range(0, 1));
      hit        = (kind != 3) && (k == s + d);
      wb_ack_i   = hit && (kind == 0 || kind == 2);
      wb_err_i   = hit && (kind != 0);
      wb_dat_i   = hit ? dat : $urandom;
      @(negedge clk_i);
    end
    // Completion cycle: occasionally throw a stray ack that must be ignored.
    wb_stall_i = 1'b0;
    wb_ack_i   = ($urandom_range(0, 3) == 0);
    wb_err_i   = 1'b0;
    wb_dat_i   = $urandom;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
  endtask

  // ---------------- monitor ----------------
  int stb_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (rst_i) begin
        stb_cnt = 0;
        continue;
      end
      if (wb_stb_o) begin
        if (exp_q.size() == 0) begin
          chk("stb_unexpected", wb_stb_o, 0);
        end else begin
          e = exp_q[0];
          chk("wb_adr", wb_adr_o, e.adr);
          chk("wb_sel", wb_sel_o, e.sel);
          chk("wb_we", wb_we_o, e.we);
          chk("wb_cyc_with_stb", wb_cyc_o, 1);
          if (e.we) chk("wb_dat", wb_dat_o, e.wdata);
          stb_cnt++;
        end
      end
      if (lsu_req_done_o) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", lsu_req_done_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk("err", lsu_err_o, e.err);
          chk("rdata", lsu_rdata_o, e.rdata);
          chk("done_cycle", cycle, e.done_cyc);
          chk("stb_cycles", stb_cnt, e.stb_cyc);
          chk("cyc_in_resp", {wb_cyc_o, wb_stb_o}, 0);
        end
        stb_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    logic we;
    repeat (2) @(negedge clk_i);
    chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    chk("rst_adr_sel", {wb_adr_o, wb_sel_o}, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_done_err", {lsu_req_done_o, lsu_err_o}, 0);
    chk("rst_rdata", lsu_rdata_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_after_rst", {wb_cyc_o, wb_stb_o, lsu_req_done_o}, 0);

    // Zero-wait load, misaligned byte address.
    run_txn(32'h0000_1006, 1'b0, 4'b0010, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);
    // Store with 3 stall cycles and ack two cycles after acceptance.
    run_txn(32'h0000_0020, 1'b1, 4'b0100, 32'h00AB_0000, 3, 2, 0, 32'h1234_5678);
    // Simultaneous err and ack on a load.
    run_txn(32'h0000_0040, 1'b0, 4'b1111, 32'h0, 0, 1, 2, 32'hCAFE_F00D);
    // Slave never answers: forced termination.
    run_txn(32'h0000_0080, 1'b0, 4'b1111, 32'h0, 1, 0, 3, 32'h0);

    // Reset asserted in the middle of WAIT.
    begin
      exp_t e;
      e = '0;
      e.adr = 32'h0000_0100;
      e.sel = 4'hF;
      exp_q.push_back(e);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h0000_0100;
      @(negedge clk_i);
      lsu_req_i = 1'b0; wb_stall_i = 1'b0;
      @(negedge clk_i);
      chk("wait_cyc_before_rst", {wb_cyc_o, wb_stb_o}, 2'b10);
      #3 rst_i = 1'b1;
      #1;
      chk("rst_mid_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
      chk("rst_mid_done", lsu_req_done_o, 0);
      exp_q.delete();
      model_rdata = 32'h0;
      @(negedge clk_i);
      chk("rst_mid_rdata", lsu_rdata_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_idle", {wb_cyc_o, lsu_req_done_o}, 0);
    end
    run_txn(32'h0000_0204, 1'b0, 4'b0001, 32'h0, 0, 1, 0, 32'h5A5A_A5A5);

    // Back-to-back loads, then a stray ack in IDLE.
    run_txn(32'h0000_0300, 1'b0, 4'h0, 32'h0, 0, 0, 0, 32'h1111_2222);
    run_txn(32'h0000_0304, 1'b0, 4'h0, 32'h0, 1, 1, 0, 32'h3333_4444);
    wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    chk("stray_ack_done", lsu_req_done_o, 0);
    @(negedge clk_i);
    chk("stray_ack_done2", lsu_req_done_o, 0);
    chk("stray_ack_rdata", lsu_rdata_o, model_rdata);

    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      kind = (kind <= 5) ? 0 : (kind == 6) ? 1 : (kind == 7) ? 2 : 3;
      run_txn($urandom, we, 4'($urandom), $urandom, $urandom_range(0, 3),
              $urandom_range(0, 4), kind, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (3) @(negedge clk_i);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
